// File: rtl/mu01_boot_loader.sv
// Boot loader for the mu01 CPU: parses a framed byte stream, writes 16-bit words into
// program memory and releases the CPU from reset once the data checksum verifies.
module mu01_boot_loader #(
  parameter int         AW        = 12,
  parameter int         DW        = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_reset,
  output logic          done,
  output logic          err
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR_H, S_ADDR_L, S_CNT_H, S_CNT_L,
    S_DATA_H, S_DATA_L, S_CSUM, S_RUN, S_ERROR
  } state_t;

  localparam logic [16:0] MAX_CNT = 17'(1) << AW;

  state_t        state, state_nxt;
  logic [7:0]    hdr_h;
  logic [7:0]    csum;
  logic [AW-1:0] addr;
  logic [15:0]   cnt;
  logic [15:0]   hdr_word;
  logic          xfer;
  logic          cnt_bad;

  // in_ready depends on state alone so the handshake never loops back through xfer
  assign in_ready = (state != S_RUN) && (state != S_ERROR);
  assign xfer     = in_valid & in_ready;
  assign hdr_word = {hdr_h, in_data};
  assign cnt_bad  = (hdr_word == 16'd0) || ({1'b0, hdr_word} > MAX_CNT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cpu_reset = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      S_IDLE:   if (xfer && in_data == SYNC_BYTE) state_nxt = S_ADDR_H;
      S_ADDR_H: if (xfer) state_nxt = S_ADDR_L;
      S_ADDR_L: if (xfer) state_nxt = S_CNT_H;
      S_CNT_H:  if (xfer) state_nxt = S_CNT_L;
      S_CNT_L:  if (xfer) state_nxt = cnt_bad ? S_ERROR : S_DATA_H;
      S_DATA_H: if (xfer) state_nxt = S_DATA_L;
      S_DATA_L: if (xfer) state_nxt = (cnt == 16'd1) ? S_CSUM : S_DATA_H;
      S_CSUM:   if (xfer) state_nxt = (in_data == csum) ? S_RUN : S_ERROR;
      S_RUN: begin
        cpu_reset = 1'b0;
        done      = 1'b1;
        if (reload) state_nxt = S_IDLE;
      end
      S_ERROR: begin
        err = 1'b1;
        if (reload) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // hdr_h holds whichever high byte is pending: address, count or data word
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hdr_h     <= 8'd0;
      csum      <= 8'd0;
      addr      <= '0;
      cnt       <= 16'd0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (xfer) begin
        case (state)
          S_IDLE:   if (in_data == SYNC_BYTE) csum <= 8'd0;
          S_ADDR_H: hdr_h <= in_data;
          S_ADDR_L: addr  <= hdr_word[AW-1:0];
          S_CNT_H:  hdr_h <= in_data;
          S_CNT_L:  cnt   <= hdr_word;
          S_DATA_H: begin
            hdr_h <= in_data;
            csum  <= csum ^ in_data;
          end
          S_DATA_L: begin
            csum      <= csum ^ in_data;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= hdr_word;
            addr      <= addr + AW'(1);
            cnt       <= cnt - 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mu01_boot_loader.sv
// Directed bench for mu01_boot_loader: frames, checksum pass/fail, address wrap,
// bad counts, stalled streams, reload and mid-frame reset.
module tb_mu01_boot_loader;

  logic        clk      = 1'b0;
  logic        reset    = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data  = 8'h00;
  logic        reload   = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [11:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [11:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic [7:0]  frame[$];

  mu01_boot_loader dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // one entry per high cycle of mem_we, so a stretched strobe shows up as an extra write
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    int waited;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check_output("accept_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data  = 8'h33;
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int gap);
    foreach (fr[i]) begin
      apply_stimulus(fr[i]);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic check_log(input string tag);
    repeat (2) @(negedge clk);
    check_output({tag, "_nwr"}, wr_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < wr_addr_q.size(); i++) begin
      check_output($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], exp_addr_q[i]);
      check_output($sformatf("%s_data%0d", tag, i), wr_data_q[i], exp_data_q[i]);
    end
    wr_addr_q.delete();
    wr_data_q.delete();
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  initial begin
    #12;
    check_output("rst_in_ready", in_ready, 1);
    check_output("rst_mem_we", mem_we, 0);
    check_output("rst_mem_addr", mem_addr, 0);
    check_output("rst_mem_wdata", mem_wdata, 0);
    check_output("rst_cpu_reset", cpu_reset, 1);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;

    // good two-word frame, with done timing around the CSUM byte
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h80, 8'h01, 8'hA0, 8'h01};
    send_frame(frame, 0);
    check_output("t1_pre_done", done, 0);
    check_output("t1_pre_cpu_reset", cpu_reset, 1);
    apply_stimulus(8'h20);
    check_output("t1_done", done, 1);
    check_output("t1_cpu_reset", cpu_reset, 0);
    check_output("t1_err", err, 0);
    check_output("t1_in_ready", in_ready, 0);
    exp_addr_q = '{12'h000, 12'h001};
    exp_data_q = '{16'h8001, 16'hA001};
    check_log("t1");
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_output("t1_run_hold_done", done, 1);
    check_output("t1_run_hold_ready", in_ready, 0);
    do_reload();

    // same frame, bad checksum
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h80, 8'h01, 8'hA0, 8'h01, 8'h21};
    send_frame(frame, 0);
    check_output("t2_err", err, 1);
    check_output("t2_done", done, 0);
    check_output("t2_cpu_reset", cpu_reset, 1);
    check_log("t2");
    do_reload();

    // address wrap from 0FFF to 0000
    frame = '{8'hA5, 8'h0F, 8'hFF, 8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_frame(frame, 0);
    check_output("t3_done", done, 1);
    exp_addr_q = '{12'hFFF, 12'h000};
    exp_data_q = '{16'h1234, 16'h5678};
    check_log("t3");
    do_reload();

    // junk before sync, zero count
    frame = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame(frame, 0);
    check_output("t4_err", err, 1);
    check_output("t4_in_ready", in_ready, 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    check_log("t4");
    do_reload();

    // count one beyond the memory size
    frame = '{8'hA5, 8'hF1, 8'h23, 8'h10, 8'h01};
    send_frame(frame, 0);
    check_output("t4b_err", err, 1);
    check_log("t4b");
    do_reload();

    // stalled stream, then reload from RUN
    frame = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h02, 8'h80, 8'h01, 8'hA0, 8'h01, 8'h20};
    send_frame(frame, 1);
    check_output("t5_done", done, 1);
    exp_addr_q = '{12'h000, 12'h001};
    exp_data_q = '{16'h8001, 16'hA001};
    check_log("t5");
    do_reload();
    check_output("t5_rl_in_ready", in_ready, 1);
    check_output("t5_rl_done", done, 0);
    check_output("t5_rl_cpu_reset", cpu_reset, 1);

    // reset in the middle of a frame, then a fresh frame
    frame = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12};
    send_frame(frame, 0);
    #2;
    reset = 1'b0;
    #1;
    check_output("t6_rst_mem_addr", mem_addr, 0);
    check_output("t6_rst_mem_wdata", mem_wdata, 0);
    check_output("t6_rst_mem_we", mem_we, 0);
    check_output("t6_rst_cpu_reset", cpu_reset, 1);
    check_output("t6_rst_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b1;
    frame = '{8'hA5, 8'h00, 8'h20, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
    send_frame(frame, 0);
    check_output("t6_done", done, 1);
    check_output("t6_cpu_reset", cpu_reset, 0);
    exp_addr_q = '{12'h020};
    exp_data_q = '{16'hBEEF};
    check_log("t6");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
